// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the shared 7-segment display. Each owner keeps the display for a minimum dwell time.
// A one-cycle blank gap separates consecutive owners.
module hex_display_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int DIGITS       = 4,
  parameter int CLK_PER_TICK = 5,
  parameter int DWELL_TICKS  = 8,
  localparam int OW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          req,
  input  logic [NUM_SRC*DIGITS*4-1:0] data,
  output logic [NUM_SRC-1:0]          grant,
  output logic [OW-1:0]               owner,
  output logic [DIGITS*4-1:0]         hex_out,
  output logic                        valid
);

  localparam int TW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam int DW = $clog2(DWELL_TICKS + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] OWN    = 2'd1;
  localparam logic [1:0] SWITCH = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DIGITS*4-1:0] hex_q, hex_d;
  logic                valid_q, valid_d;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [DW-1:0]       dwell_cnt_q, dwell_cnt_d;

  logic                tick;
  logic                pickFound;
  logic [OW-1:0]       pickIdx;
  logic [NUM_SRC-1:0]  ownerMask;
  logic                otherPend;
  logic                dwellDone;
  logic                ownExit;

  assign tick      = (tick_cnt_q == TW'(CLK_PER_TICK - 1));
  assign ownerMask = NUM_SRC'(1) << owner_q;
  assign otherPend = |(req & ~ownerMask);
  assign dwellDone = (dwell_cnt_q == DW'(DWELL_TICKS));
  assign ownExit   = !req[owner_q] || (dwellDone && otherPend);

  // First requester at or after rr_ptr, wrapping around the source count.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!pickFound && req[(int'(rr_ptr_q) + k) % NUM_SRC]) begin
        pickFound = 1'b1;
        pickIdx   = OW'((int'(rr_ptr_q) + k) % NUM_SRC);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    hex_d       = hex_q;
    valid_d     = valid_q;
    dwell_cnt_d = dwell_cnt_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);

    case (state_q)
      OWN: begin
        hex_d = data[owner_q*DIGITS*4 +: DIGITS*4];
        if (tick && !dwellDone) begin
          dwell_cnt_d = dwell_cnt_q + DW'(1);
        end
        if (ownExit) begin
          state_d  = SWITCH;
          grant_d  = '0;
          valid_d  = 1'b0;
          rr_ptr_d = OW'((int'(owner_q) + 1) % NUM_SRC);
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        // IDLE and the SWITCH gap both hand the display to the next requester, if any.
        grant_d = '0;
        valid_d = 1'b0;
        if (pickFound) begin
          state_d     = OWN;
          grant_d     = NUM_SRC'(1) << pickIdx;
          owner_d     = pickIdx;
          dwell_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      hex_q       <= '0;
      valid_q     <= 1'b0;
      tick_cnt_q  <= '0;
      dwell_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      hex_q       <= hex_d;
      valid_q     <= valid_d;
      tick_cnt_q  <= tick_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign hex_out = hex_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Randomized bench for hex_display_arbiter, compared against a behavioural ownership model.
module tb_hex_display_arbiter;

  localparam int N     = 4;
  localparam int DIG   = 4;
  localparam int CPT   = 5;
  localparam int DWELL = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [63:0]   data;
  logic [N-1:0]  grant;
  logic [1:0]    owner;
  logic [15:0]   hex_out;
  logic          valid;

  int vecCount  = 0;
  int missCount = 0;

  // Model state: who owns the display, whether we are in the gap, and tick accounting.
  bit          mBusy, mGap;
  int          mOwner, mPtr, mTicks, mPhase;
  logic [N-1:0] mGrant;
  logic [1:0]  mOwnerOut;
  logic [15:0] mHex;
  logic        mValid;

  hex_display_arbiter #(
    .NUM_SRC(N), .DIGITS(DIG), .CLK_PER_TICK(CPT), .DWELL_TICKS(DWELL)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .data(data),
    .grant(grant), .owner(owner), .hex_out(hex_out), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelStep();
    bit tickNow, leave;
    int found;
    if (!reset) begin
      mBusy = 0; mGap = 0; mOwner = 0; mPtr = 0; mTicks = 0; mPhase = 0;
      mGrant = '0; mOwnerOut = '0; mHex = '0; mValid = 1'b0;
      return;
    end
    tickNow = (mPhase == CPT - 1);
    mPhase  = (mPhase + 1) % CPT;
    if (mBusy) begin
      mHex  = data[mOwner*16 +: 16];
      leave = !req[mOwner] || (mTicks == DWELL && (req & ~(N'(1) << mOwner)) != 0);
      if (tickNow && mTicks < DWELL) mTicks++;
      if (leave) begin
        mBusy = 0; mGap = 1; mPtr = (mOwner + 1) % N;
        mGrant = '0; mValid = 1'b0;
      end else begin
        mValid = 1'b1;
      end
    end else begin
      mGap  = 0;
      found = -1;
      for (int k = 0; k < N; k++)
        if (found < 0 && req[(mPtr + k) % N]) found = (mPtr + k) % N;
      mValid = 1'b0;
      mGrant = '0;
      if (found >= 0) begin
        mBusy = 1; mOwner = found; mTicks = 0;
        mGrant = N'(1) << found; mOwnerOut = 2'(found);
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [N-1:0] rq, input logic [63:0] d, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      checkOutput("grant", 64'(grant), 64'(mGrant));
      checkOutput("owner", 64'(owner), 64'(mOwnerOut));
      checkOutput("hex_out", 64'(hex_out), 64'(mHex));
      checkOutput("valid", 64'(valid), 64'(mValid));
      reset = rst; req = rq; data = d;
      @(posedge clk);
      modelStep();
    end
  endtask

  initial begin
    logic [N-1:0] rq;
    logic [63:0]  d;
    logic         rst;
    reset = 1'b0; req = '1; data = '1;
    @(posedge clk);
    modelStep();
    applyStimulus(1'b0, 4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 3);
    applyStimulus(1'b1, 4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 3);
    applyStimulus(1'b0, 4'b0000, 64'h0, 2);
    applyStimulus(1'b1, 4'b0100, 64'h0000_1234_0000_0000, 6);
    applyStimulus(1'b1, 4'b0100, 64'h0000_5678_0000_0000, 4);
    applyStimulus(1'b0, 4'b0000, 64'h0, 1);
    applyStimulus(1'b1, 4'b1111, 64'h4444_3333_2222_1111, 220);
    applyStimulus(1'b0, 4'b0000, 64'h0, 1);
    applyStimulus(1'b1, 4'b0010, 64'hAAAA_BBBB_CCCC_DDDD, 8);
    applyStimulus(1'b1, 4'b1010, 64'hAAAA_BBBB_CCCC_DDDD, 10);
    applyStimulus(1'b1, 4'b1000, 64'hAAAA_BBBB_CCCC_DDDD, 6);
    applyStimulus(1'b1, 4'b1111, 64'h1357_2468_9ABC_DEF0, 60);
    applyStimulus(1'b0, 4'b1111, 64'h1357_2468_9ABC_DEF0, 1);
    applyStimulus(1'b1, 4'b1111, 64'h1357_2468_9ABC_DEF0, 5);
    rq = 4'b1111; d = 64'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) rq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 6) == 0) d = {$urandom, $urandom};
      rst = ($urandom_range(0, 399) != 0);
      applyStimulus(rst, rq, d, 1);
    end
    @(negedge clk);
    checkOutput("grant_final", 64'(grant), 64'(mGrant));
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
